serial_word_tx: RTL and testbench

SERIAL_WORD_TX -- requirements
Module: serial_word_tx

---
 rtl/serial_pkg.sv | 15 +
 rtl/serial_word_tx_bit_timer.sv | 31 +++
 rtl/serial_word_tx.sv | 104 ++++++++++
 tb/tb_serial_word_tx.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared types and helpers for the serial word transmitter.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  // Counter width for a 0..range_n-1 count, never narrower than one bit.
  function automatic int cnt_width(input int range_n);
    return (range_n > 1) ? $clog2(range_n) : 1;
  endfunction

endpackage

// File: rtl/serial_word_tx_bit_timer.sv
// Bit-period divider: tick marks the last clk cycle of each serial bit while run is high.
module bit_timer
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int               DIV_W    = cnt_width(CLKS_PER_BIT);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLKS_PER_BIT - 1);

  logic [DIV_W-1:0] div_cnt;

  assign tick = run && (div_cnt == DIV_LAST);

  // Held at zero whenever not running, so every frame starts a fresh bit period.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
    end else if (!run || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_word_tx.sv
// LSB-first serialiser with valid/ready load, per-bit sample strobe, abort and frame-done pulse.
module serial_word_tx
  import serial_pkg::*;
#(
  parameter int   NUM_BITS     = 8,
  parameter int   CLKS_PER_BIT = 1,
  parameter logic IDLE_LEVEL   = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_BITS-1:0] data_in,
  input  logic                data_valid,
  output logic                data_ready,
  input  logic                abort,
  output logic                serial_out,
  output logic                shift_enable,
  output logic                frame_done,
  output logic                busy
);

  localparam int               BIT_W    = cnt_width(NUM_BITS);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(NUM_BITS - 1);

  state_t              state;
  state_t              state_nxt;
  logic [NUM_BITS-1:0] word;
  logic [BIT_W-1:0]    bit_cnt;
  logic                accept;
  logic                run;
  logic                tick;
  logic                last_bit;
  logic                cancel;

  assign accept   = data_valid && (state == IDLE);
  assign cancel   = abort && (state != IDLE);
  // Abort masks the strobe in the same cycle so no bit is sampled on the cancel edge.
  assign run      = (state == SHIFT) && !abort;
  assign last_bit = (bit_cnt == BIT_LAST);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk (clk),
    .rst (rst),
    .run (run),
    .tick(tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (data_valid) state_nxt = SHIFT;
      SHIFT: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (tick && last_bit) begin
          state_nxt = DONE;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    data_ready   = (state == IDLE);
    busy         = (state != IDLE);
    serial_out   = IDLE_LEVEL;
    shift_enable = tick;
    frame_done   = 1'b0;
    if (state == SHIFT) begin
      serial_out = word[0];
    end
    if (state == DONE) begin
      frame_done = !abort;
    end
  end

  // bit_cnt clears on the last strobe instead of counting to NUM_BITS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (cancel) begin
      word    <= '0;
      bit_cnt <= '0;
    end else if (accept) begin
      word    <= data_in;
      bit_cnt <= '0;
    end else if (tick) begin
      word    <= {1'b0, word[NUM_BITS-1:1]};
      bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_word_tx.sv
// Directed bench for serial_word_tx: 8-bit/2-clk instance with loopback receiver, plus 2-bit/1-clk instance.
module tb_serial_word_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic [7:0] din8;
  logic       dv8, ab8, rdy8, so8, se8, fd8, busy8;
  logic [1:0] din2;
  logic       dv2, ab2, rdy2, so2, se2, fd2, busy2;

  logic [7:0] rx;
  int         checks   = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  serial_word_tx #(.NUM_BITS(8), .CLKS_PER_BIT(2), .IDLE_LEVEL(1'b0)) dut8 (
    .clk(clk), .rst(rst), .data_in(din8), .data_valid(dv8), .data_ready(rdy8),
    .abort(ab8), .serial_out(so8), .shift_enable(se8), .frame_done(fd8), .busy(busy8)
  );

  serial_word_tx #(.NUM_BITS(2), .CLKS_PER_BIT(1), .IDLE_LEVEL(1'b0)) dut2 (
    .clk(clk), .rst(rst), .data_in(din2), .data_valid(dv2), .data_ready(rdy2),
    .abort(ab2), .serial_out(so2), .shift_enable(se2), .frame_done(fd2), .busy(busy2)
  );

  // Downstream LSB-first receiver sampling on the strobe edge.
  always @(posedge clk) begin
    if (se8) rx <= {so8, rx[7:1]};
  end

  typedef struct {
    logic       dv;
    logic [7:0] din;
    logic       so;
    logic       se;
    logic       fd;
    logic       rdy;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready8();
    int n;
    n = 0;
    while (!rdy8 && n < 50) begin
      step();
      n++;
    end
  endtask

  task automatic wait_fd8(output int n);
    n = 0;
    while (!fd8 && n < 40) begin
      step();
      n++;
    end
  endtask

  task automatic send8(input string name, input logic [7:0] w);
    int n;
    wait_ready8();
    dv8  = 1'b1;
    din8 = w;
    step();
    dv8  = 1'b0;
    din8 = ~w;
    wait_fd8(n);
    check({name, "_frame_done"}, fd8, 1'b1);
    check({name, "_rx_word"}, rx, w);
  endtask

  initial begin
    int n;
    int fd_seen;
    dv8 = 1'b0; ab8 = 1'b0; din8 = '0;
    dv2 = 1'b0; ab2 = 1'b0; din2 = '0;

    tbl[0]  = '{1'b1, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[3]  = '{1'b1, 8'hFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b1, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b1, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[8]  = '{1'b1, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b1, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[10] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[12] = '{1'b0, 8'h3C, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 8'h3C, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[14] = '{1'b0, 8'h3C, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[15] = '{1'b0, 8'h3C, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset values, before any clock edge
    #2;
    check("rst_serial_out", so8, 1'b0);
    check("rst_shift_enable", se8, 1'b0);
    check("rst_frame_done", fd8, 1'b0);
    check("rst_busy", busy8, 1'b0);
    check("rst_data_ready", rdy8, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // 0xA5 frame, cycle by cycle; accepted on the first edge after release
    for (int k = 0; k < 18; k++) begin
      dv8  = tbl[k].dv;
      din8 = tbl[k].din;
      step();
      check($sformatf("a5_so_c%0d", k), so8, tbl[k].so);
      check($sformatf("a5_se_c%0d", k), se8, tbl[k].se);
      check($sformatf("a5_fd_c%0d", k), fd8, tbl[k].fd);
      check($sformatf("a5_rdy_c%0d", k), rdy8, tbl[k].rdy);
      check($sformatf("a5_busy_c%0d", k), busy8, !tbl[k].rdy);
      if (k == 16) check("a5_rx_word", rx, 8'hA5);
    end
    dv8 = 1'b0;

    // Loopback words
    send8("lb00", 8'h00);
    send8("lbff", 8'hFF);
    send8("lb3c", 8'h3C);

    // Back-to-back frames with data_valid held high
    wait_ready8();
    dv8  = 1'b1;
    din8 = 8'h12;
    step();
    din8 = 8'h34;
    wait_fd8(n);
    check("b2b_first_len", n, 16);
    check("b2b_first_rx", rx, 8'h12);
    step();
    check("b2b_ready_after_done", rdy8, 1'b1);
    step();
    check("b2b_second_accepted", busy8, 1'b1);
    dv8  = 1'b0;
    din8 = 8'h77;
    wait_fd8(n);
    check("b2b_second_fd", fd8, 1'b1);
    check("b2b_second_rx", rx, 8'h34);

    // Abort after three bits, in a cycle where the strobe would be high
    wait_ready8();
    dv8  = 1'b1;
    din8 = 8'h96;
    step();
    dv8 = 1'b0;
    repeat (7) step();
    check("abort_pre_strobe", se8, 1'b1);
    ab8 = 1'b1;
    #1;
    check("abort_strobe_masked", se8, 1'b0);
    step();
    ab8 = 1'b0;
    check("abort_busy", busy8, 1'b0);
    check("abort_serial_out", so8, 1'b0);
    check("abort_ready", rdy8, 1'b1);
    fd_seen = 0;
    repeat (20) begin
      step();
      if (fd8) fd_seen++;
    end
    check("abort_no_frame_done", fd_seen, 0);
    send8("post_abort", 8'h5A);

    // Asynchronous reset mid-frame
    wait_ready8();
    dv8  = 1'b1;
    din8 = 8'hE7;
    step();
    dv8 = 1'b0;
    repeat (5) step();
    check("midrst_pre_busy", busy8, 1'b1);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_busy", busy8, 1'b0);
    check("midrst_ready", rdy8, 1'b1);
    check("midrst_serial_out", so8, 1'b0);
    check("midrst_shift_enable", se8, 1'b0);
    check("midrst_frame_done", fd8, 1'b0);
    #1;
    rst = 1'b0;
    step();
    check("midrst_stays_idle", busy8, 1'b0);
    send8("post_rst", 8'hC3);

    // Two-bit word, one clk per bit
    dv2  = 1'b1;
    din2 = 2'b10;
    step();
    dv2 = 1'b0;
    check("n2_se_b0", se2, 1'b1);
    check("n2_so_b0", so2, 1'b0);
    step();
    check("n2_se_b1", se2, 1'b1);
    check("n2_so_b1", so2, 1'b1);
    step();
    check("n2_fd", fd2, 1'b1);
    check("n2_se_done", se2, 1'b0);
    step();
    check("n2_ready", rdy2, 1'b1);
    check("n2_fd_clear", fd2, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
